pll_lock_supervisor: RTL and testbench

- Controls the clock generator from the far side: drives the PLL reset, watches the PLL `locked` output, and releases a system reset to the accelerator only after lock has been stable.
- Runs on the free-running 50 MHz reference clock, so it keeps operating when the PLL output clock is absent.
- Re-resets the PLL on lock timeout or loss of lock, with bounded retries, a fail flag, and a loss-of-lock counter for software.

---
 rtl/pll_lock_supervisor.sv | 195 +++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences the PLL reset from the free-running reference
// clock, qualifies PLL lock, and releases the accelerator reset once lock has
// been stable. Retries on timeout or lock loss, flags FAIL when retries run out.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned STABLE_CYCLES       = 1024,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst_out,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_pulse_cnt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] r_stable_cnt;
    logic [1:0]       r_retry_count;
    logic [7:0]       r_lock_loss_count;
    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_ready;
    logic             r_fail;

    logic             w_lock_s;
    logic             w_sync_clr;
    logic             w_timeout;
    logic             w_stable_done;
    logic             w_retry_ok;
    logic             w_retry_inc;

    // Lock is meaningless while the PLL is held in reset, so the synchronizer
    // is flushed then; a stale high can never shortcut the stability check.
    assign w_lock_s      = r_sync2;
    assign w_sync_clr    = (r_state == S_RESET_PLL);
    assign w_timeout     = (r_timer >= TIMEOUT_LAST);
    assign w_stable_done = w_lock_s && (r_stable_cnt == STABLE_LAST);
    assign w_retry_ok    = (r_retry_count < RETRY_MAX);

    // Next-state decision; force_relock overrides all transitions.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        if (force_relock) begin
            w_state_nxt = S_RESET_PLL;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_pulse_cnt == PULSE_LAST) begin
                        w_state_nxt = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_nxt = S_STABILIZE;
                    end else if (w_timeout) begin
                        if (w_retry_ok) begin
                            w_state_nxt = S_RESET_PLL;
                            w_retry_inc = 1'b1;
                        end else begin
                            w_state_nxt = S_FAIL;
                        end
                    end
                end
                S_STABILIZE: begin
                    if (w_stable_done) begin
                        w_state_nxt = S_RUN;
                    end else if (w_timeout) begin
                        if (w_retry_ok) begin
                            w_state_nxt = S_RESET_PLL;
                            w_retry_inc = 1'b1;
                        end else begin
                            w_state_nxt = S_FAIL;
                        end
                    end else if (!w_lock_s) begin
                        w_state_nxt = S_WAIT_LOCK;
                    end
                end
                S_RUN: begin
                    if (!w_lock_s) begin
                        w_state_nxt = S_RESET_PLL;
                    end
                end
                S_FAIL: begin
                    w_state_nxt = S_FAIL;
                end
                default: begin
                    w_state_nxt = S_RESET_PLL;
                end
            endcase
        end
    end

    // State, counters, synchronizer and Moore outputs decoded from next state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state           <= S_RESET_PLL;
            r_sync1           <= 1'b0;
            r_sync2           <= 1'b0;
            r_pulse_cnt       <= '0;
            r_timer           <= '0;
            r_stable_cnt      <= '0;
            r_retry_count     <= '0;
            r_lock_loss_count <= '0;
            r_pll_rst         <= 1'b1;
            r_sys_rst         <= 1'b1;
            r_ready           <= 1'b0;
            r_fail            <= 1'b0;
        end else begin
            r_sync1   <= w_sync_clr ? 1'b0 : pll_locked;
            r_sync2   <= w_sync_clr ? 1'b0 : r_sync1;
            r_state   <= w_state_nxt;
            r_pll_rst <= (w_state_nxt == S_RESET_PLL);
            r_sys_rst <= (w_state_nxt != S_RUN);
            r_ready   <= (w_state_nxt == S_RUN);
            r_fail    <= (w_state_nxt == S_FAIL);

            if (force_relock) begin
                r_pulse_cnt   <= '0;
                r_timer       <= '0;
                r_stable_cnt  <= '0;
                r_retry_count <= '0;
            end else begin
                if (w_retry_inc) begin
                    r_retry_count <= r_retry_count + 2'd1;
                end else if (w_state_nxt == S_RUN) begin
                    r_retry_count <= '0;
                end

                case (r_state)
                    S_RESET_PLL: begin
                        r_pulse_cnt  <= (w_state_nxt == S_WAIT_LOCK) ? '0
                                        : r_pulse_cnt + CNT_W'(1);
                        r_timer      <= '0;
                        r_stable_cnt <= '0;
                    end
                    S_WAIT_LOCK: begin
                        r_pulse_cnt  <= '0;
                        r_timer      <= r_timer + CNT_W'(1);
                        r_stable_cnt <= '0;
                    end
                    S_STABILIZE: begin
                        r_pulse_cnt  <= '0;
                        r_timer      <= r_timer + CNT_W'(1);
                        r_stable_cnt <= w_lock_s ? r_stable_cnt + CNT_W'(1) : '0;
                    end
                    S_RUN: begin
                        r_pulse_cnt  <= '0;
                        r_timer      <= '0;
                        r_stable_cnt <= '0;
                        if (!w_lock_s && (r_lock_loss_count != 8'hFF)) begin
                            r_lock_loss_count <= r_lock_loss_count + 8'd1;
                        end
                    end
                    default: begin
                        r_pulse_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign pll_rst         = r_pll_rst;
    assign sys_rst_out     = r_sys_rst;
    assign ready           = r_ready;
    assign fail            = r_fail;
    assign retry_count     = r_retry_count;
    assign lock_loss_count = r_lock_loss_count;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters
// (pulse 4, timeout 40, stable 8, two retries).
module tb_pll_lock_supervisor;

    localparam int SIG_PLL_RST = 0;
    localparam int SIG_READY   = 1;
    localparam int SIG_FAIL    = 2;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rst_out;
    logic       ready;
    logic       fail;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;

    int n_checks;
    int n_fail;
    int n_steps;
    int n_bound_miss;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(40),
        .STABLE_CYCLES      (8),
        .MAX_RETRIES        (2),
        .CNT_W              (16)
    ) u_dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .force_relock   (force_relock),
        .pll_rst        (pll_rst),
        .sys_rst_out    (sys_rst_out),
        .ready          (ready),
        .fail           (fail),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    // 50 MHz reference clock
    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    // Hard stop in case the sequence wedges
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs driven and outputs sampled 1 ns after it
    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Count edges until the selected output reaches val, bounded by limit
    task automatic steps_until(input int sel, input logic val, input int limit, output int n);
        logic s;
        n = 0;
        do begin
            step();
            n++;
            case (sel)
                SIG_PLL_RST: s = pll_rst;
                SIG_READY:   s = ready;
                default:     s = fail;
            endcase
        end while ((s !== val) && (n < limit));
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_pll_rst"},   32'(pll_rst), 32'd1);
        chk({pfx, "_sys_rst"},   32'(sys_rst_out), 32'd1);
        chk({pfx, "_ready"},     32'(ready), 32'd0);
        chk({pfx, "_fail"},      32'(fail), 32'd0);
        chk({pfx, "_retry"},     32'(retry_count), 32'd0);
        chk({pfx, "_lock_loss"}, 32'(lock_loss_count), 32'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        n_bound_miss = 0;
        rst          = 1'b1;
        pll_locked   = 1'b1;
        force_relock = 1'b0;

        // 1: power-up with lock held high
        step_n(3);
        chk_reset_values("t1_rst");
        rst = 1'b0;
        steps_until(SIG_PLL_RST, 1'b0, 30, n_steps);
        chk("t1_pll_rst_len", 32'(n_steps), 32'd4);
        steps_until(SIG_READY, 1'b1, 40, n_steps);
        chk("t1_ready_lat", 32'(n_steps), 32'd11);
        chk("t1_sys_rst", 32'(sys_rst_out), 32'd0);
        chk("t1_retry", 32'(retry_count), 32'd0);
        chk("t1_pll_rst", 32'(pll_rst), 32'd0);

        // 3: one-cycle lock glitch during stabilization restarts the count
        force_relock = 1'b1;
        step();
        force_relock = 1'b0;
        chk("t3_force_ready", 32'(ready), 32'd0);
        chk("t3_force_pll_rst", 32'(pll_rst), 32'd1);
        step_n(12);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        steps_until(SIG_READY, 1'b1, 40, n_steps);
        chk("t3_ready_lat", 32'(n_steps), 32'd11);
        chk("t3_retry", 32'(retry_count), 32'd0);
        chk("t3_pll_rst", 32'(pll_rst), 32'd0);
        chk("t3_lock_loss", 32'(lock_loss_count), 32'd0);

        // 4: lock loss in RUN, then relock
        pll_locked = 1'b0;
        steps_until(SIG_READY, 1'b0, 20, n_steps);
        chk("t4_drop_lat", 32'(n_steps), 32'd3);
        chk("t4_sys_rst", 32'(sys_rst_out), 32'd1);
        chk("t4_lock_loss", 32'(lock_loss_count), 32'd1);
        chk("t4_pll_rst_on", 32'(pll_rst), 32'd1);
        pll_locked = 1'b1;
        steps_until(SIG_PLL_RST, 1'b0, 30, n_steps);
        chk("t4_pll_rst_len", 32'(n_steps), 32'd4);
        steps_until(SIG_READY, 1'b1, 40, n_steps);
        chk("t4_relock_lat", 32'(n_steps), 32'd11);
        chk("t4_retry", 32'(retry_count), 32'd0);

        // 2: lock never returns -> three attempts then FAIL
        pll_locked = 1'b0;
        steps_until(SIG_READY, 1'b0, 20, n_steps);
        chk("t2_drop_lat", 32'(n_steps), 32'd3);
        chk("t2_lock_loss", 32'(lock_loss_count), 32'd2);
        for (int a = 0; a < 3; a++) begin
            steps_until(SIG_PLL_RST, 1'b0, 30, n_steps);
            chk($sformatf("t2_pulse%0d_len", a), 32'(n_steps), 32'd4);
            if (a < 2) begin
                steps_until(SIG_PLL_RST, 1'b1, 80, n_steps);
                chk($sformatf("t2_wait%0d_len", a), 32'(n_steps), 32'd40);
                chk($sformatf("t2_retry%0d", a), 32'(retry_count), 32'(a + 1));
            end else begin
                steps_until(SIG_FAIL, 1'b1, 80, n_steps);
                chk("t2_wait_last_len", 32'(n_steps), 32'd40);
            end
        end
        chk("t2_fail", 32'(fail), 32'd1);
        chk("t2_retry_final", 32'(retry_count), 32'd2);
        chk("t2_sys_rst", 32'(sys_rst_out), 32'd1);
        chk("t2_ready", 32'(ready), 32'd0);
        step_n(20);
        chk("t2_pll_rst_held", 32'(pll_rst), 32'd0);
        chk("t2_fail_held", 32'(fail), 32'd1);

        // 5: force_relock out of FAIL, then rst together with force_relock
        force_relock = 1'b1;
        step();
        force_relock = 1'b0;
        chk("t5_fail", 32'(fail), 32'd0);
        chk("t5_retry", 32'(retry_count), 32'd0);
        chk("t5_pll_rst", 32'(pll_rst), 32'd1);
        chk("t5_lock_loss_kept", 32'(lock_loss_count), 32'd2);
        steps_until(SIG_PLL_RST, 1'b0, 30, n_steps);
        chk("t5_pll_rst_len", 32'(n_steps), 32'd4);
        step_n(5);
        rst          = 1'b1;
        force_relock = 1'b1;
        step();
        rst          = 1'b0;
        force_relock = 1'b0;
        chk_reset_values("t5_rst");

        // 6: lock-loss counter saturation
        pll_locked = 1'b1;
        steps_until(SIG_READY, 1'b1, 60, n_steps);
        chk("t6_first_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            steps_until(SIG_READY, 1'b0, 20, n_steps);
            if (ready !== 1'b0) n_bound_miss++;
            pll_locked = 1'b1;
            steps_until(SIG_READY, 1'b1, 60, n_steps);
            if (ready !== 1'b1) n_bound_miss++;
            if (i == 253) chk("t6_count_254", 32'(lock_loss_count), 32'd254);
            if (i == 254) chk("t6_count_255", 32'(lock_loss_count), 32'd255);
        end
        chk("t6_bounds", 32'(n_bound_miss), 32'd0);
        chk("t6_saturated", 32'(lock_loss_count), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
